// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared definitions for the register-file sequencer.
//   - N_DEF / A_DEF : default data width and register address width
//   - OP_*          : opcode encodings for the 2-bit op field
//   - state_t       : sequencer FSM states
package rf_seq_pkg;

    localparam int N_DEF = 16;
    localparam int A_DEF = 4;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MOVE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_t;

endpackage

// File: rtl/rf_seq_alu.sv
// rf_seq_alu: combinational add / subtract / pass-through.
// Ports:
//   op   in  2   opcode (ADD, SUB; anything else passes a through)
//   a, b in  N   operands
//   res  out N   result modulo 2^N
//   cout out 1   carry-out for ADD, borrow for SUB, 0 for pass
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] res,
    output logic         cout
);

    // One extra bit so the carry (ADD) or borrow (SUB) lands in sum[N].
    logic [N:0] sum;

    always_comb begin
        sum = {1'b0, a};
        case (op)
            OP_ADD:  sum = {1'b0, a} + {1'b0, b};
            OP_SUB:  sum = {1'b0, a} - {1'b0, b};
            default: sum = {1'b0, a};
        endcase
    end

    assign res  = sum[N-1:0];
    assign cout = sum[N];

endmodule

// File: rtl/rf_sequencer.sv
// rf_sequencer: drives an external register file through a
// IDLE -> READ -> EXEC -> WRITE sequence (LOAD goes IDLE -> WRITE).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    request strobe, taken only while ready=1
//   op, ra, rb, rd, imm      request fields (latched on accept)
//   ready                    high only in IDLE
//   done                     one-cycle pulse in the write cycle
//   w_en, w_addr, w_data     register-file write port
//   r_en0/1, r_addr0/1       register-file read ports
//   r_data0/1                register-file read data
//   zero, carry              status flags (only with RF_SEQ_FLAGS_EN)
// Build option: define RF_SEQ_FLAGS_EN to add the zero/carry flag outputs.
// All outputs are registered; every address/data output is 0 when its
// port is not active so the shared read buses are left undriven.
module rf_sequencer
    import rf_seq_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int A = A_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [A-1:0] ra,
    input  logic [A-1:0] rb,
    input  logic [A-1:0] rd,
    input  logic [N-1:0] imm,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] w_data,
    output logic [A-1:0] w_addr,
    output logic         w_en,
    output logic [A-1:0] r_addr0,
    output logic [A-1:0] r_addr1,
    output logic         r_en0,
    output logic         r_en1,
    input  logic [N-1:0] r_data0,
    input  logic [N-1:0] r_data1
`ifdef RF_SEQ_FLAGS_EN
    ,
    output logic         zero,
    output logic         carry
`endif
);

    state_t       state;
    logic [1:0]   op_q;
    logic [A-1:0] rd_q;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic [N-1:0] alu_res;
    logic         alu_cout;

    rf_seq_alu #(.N(N)) u_alu (
        .op   (op_q),
        .a    (opa),
        .b    (opb),
        .res  (alu_res),
        .cout (alu_cout)
    );

`ifndef RF_SEQ_FLAGS_EN
    // Carry-out only feeds the flags; tie it off in the flagless build.
    logic alu_cout_unused;
    assign alu_cout_unused = alu_cout;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            w_en    <= 1'b0;
            w_addr  <= '0;
            w_data  <= '0;
            r_en0   <= 1'b0;
            r_en1   <= 1'b0;
            r_addr0 <= '0;
            r_addr1 <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            opa     <= '0;
            opb     <= '0;
`ifdef RF_SEQ_FLAGS_EN
            zero    <= 1'b0;
            carry   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        rd_q  <= rd;
                        ready <= 1'b0;
                        if (op == OP_LOAD) begin
                            // LOAD needs no operands: go straight to the write.
                            state  <= ST_WRITE;
                            w_en   <= 1'b1;
                            w_addr <= rd;
                            w_data <= imm;
                            done   <= 1'b1;
`ifdef RF_SEQ_FLAGS_EN
                            zero   <= (imm == '0);
                            carry  <= 1'b0;
`endif
                        end else begin
                            state   <= ST_READ;
                            r_en0   <= 1'b1;
                            r_en1   <= (op != OP_MOVE);
                            r_addr0 <= ra;
                            r_addr1 <= rb;
                        end
                    end
                end
                ST_READ: begin
                    // Bus 1 is not driven for MOVE, so don't sample it.
                    opa     <= r_data0;
                    opb     <= r_en1 ? r_data1 : '0;
                    r_en0   <= 1'b0;
                    r_en1   <= 1'b0;
                    r_addr0 <= '0;
                    r_addr1 <= '0;
                    state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    // w_data doubles as the result register.
                    state  <= ST_WRITE;
                    w_en   <= 1'b1;
                    w_addr <= rd_q;
                    w_data <= alu_res;
                    done   <= 1'b1;
`ifdef RF_SEQ_FLAGS_EN
                    zero   <= (alu_res == '0);
                    carry  <= alu_cout;
`endif
                end
                ST_WRITE: begin
                    state  <= ST_IDLE;
                    w_en   <= 1'b0;
                    w_addr <= '0;
                    w_data <= '0;
                    done   <= 1'b0;
                    ready  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
